// File: rtl/nh_coherent_acc.sv
// Coherent accumulator for one correlation channel: strips the NH secondary-code sign from each
// epoch, sums coh_number epochs with saturation and presents the dump over valid/ready.
module nh_coherent_acc #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 22,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          acc_en,
    input  logic          acc_clear,
    input  logic [CW-1:0] coh_number,
    input  logic          nh_apply,
    input  logic          cur_nh_code,
    input  logic          epoch_valid,
    input  logic [DW-1:0] epoch_i,
    input  logic [DW-1:0] epoch_q,
    output logic          nh_increase,
    output logic [CW-1:0] coh_cnt,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_i,
    output logic [AW-1:0] dump_q,
    output logic          dump_sat,
    output logic          overrun
);

    typedef enum logic {StIdle, StAcc} state_e;

    state_e        state;
    logic [AW-1:0] acc_i, acc_q;
    logic          sat;

    logic          accept, invert, last, sat_now;
    logic [AW-1:0] ext_i, ext_q, strip_i, strip_q, new_i, new_q;
    logic [AW:0]   sum_i, sum_q;
    logic          ovf_i, ovf_q;
    logic [CW-1:0] target;
    logic [CW:0]   cnt_inc;

    localparam logic [AW-1:0] MaxPos = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] MaxNeg = {1'b1, {(AW-1){1'b0}}};

    assign accept      = epoch_valid & acc_en & (state == StAcc) & ~acc_clear;
    assign nh_increase = accept;
    assign invert      = nh_apply & cur_nh_code;

    // Negation happens at AW width, so -2^(DW-1) is representable.
    assign ext_i   = {{(AW-DW){epoch_i[DW-1]}}, epoch_i};
    assign ext_q   = {{(AW-DW){epoch_q[DW-1]}}, epoch_q};
    assign strip_i = invert ? (~ext_i + AW'(1)) : ext_i;
    assign strip_q = invert ? (~ext_q + AW'(1)) : ext_q;

    assign sum_i = {acc_i[AW-1], acc_i} + {strip_i[AW-1], strip_i};
    assign sum_q = {acc_q[AW-1], acc_q} + {strip_q[AW-1], strip_q};
    assign ovf_i = sum_i[AW] ^ sum_i[AW-1];
    assign ovf_q = sum_q[AW] ^ sum_q[AW-1];
    assign new_i = ovf_i ? (sum_i[AW] ? MaxNeg : MaxPos) : sum_i[AW-1:0];
    assign new_q = ovf_q ? (sum_q[AW] ? MaxNeg : MaxPos) : sum_q[AW-1:0];
    assign sat_now = ovf_i | ovf_q;

    assign target  = (coh_number == '0) ? CW'(1) : coh_number;
    assign cnt_inc = {1'b0, coh_cnt} + (CW+1)'(1);
    assign last    = cnt_inc >= {1'b0, target};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= StIdle;
            acc_i      <= '0;
            acc_q      <= '0;
            sat        <= 1'b0;
            coh_cnt    <= '0;
            dump_valid <= 1'b0;
            dump_i     <= '0;
            dump_q     <= '0;
            dump_sat   <= 1'b0;
            overrun    <= 1'b0;
        end else if (acc_clear) begin
            state      <= acc_en ? StAcc : StIdle;
            acc_i      <= '0;
            acc_q      <= '0;
            sat        <= 1'b0;
            coh_cnt    <= '0;
            dump_valid <= 1'b0;
            dump_i     <= '0;
            dump_q     <= '0;
            dump_sat   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (acc_en) begin
                        state   <= StAcc;
                        acc_i   <= '0;
                        acc_q   <= '0;
                        sat     <= 1'b0;
                        coh_cnt <= '0;
                    end
                end
                StAcc: begin
                    if (!acc_en) begin
                        // Partial sum is dropped; the dump buffer survives.
                        state   <= StIdle;
                        acc_i   <= '0;
                        acc_q   <= '0;
                        sat     <= 1'b0;
                        coh_cnt <= '0;
                    end else if (accept && last) begin
                        acc_i   <= '0;
                        acc_q   <= '0;
                        sat     <= 1'b0;
                        coh_cnt <= '0;
                    end else if (accept) begin
                        acc_i   <= new_i;
                        acc_q   <= new_q;
                        sat     <= sat | sat_now;
                        coh_cnt <= cnt_inc[CW-1:0];
                    end
                end
                default: state <= StIdle;
            endcase

            if (accept && last) begin
                dump_valid <= 1'b1;
                dump_i     <= new_i;
                dump_q     <= new_q;
                dump_sat   <= sat | sat_now;
                if (dump_valid && !dump_ready) overrun <= 1'b1;
            end else if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end
        end
    end

endmodule
